bcd_convert_ctrl: RTL and testbench

Sequential binary-to-BCD converter that time-multiplexes a single shift-add-3 (double-dabble) stage across BIN_WIDTH clock cycles instead of unrolling BIN_WIDTH combinational stages. It accepts a binary value on a start strobe and iterates one shift/adjust step per clock. It then presents a registered packed-BCD result with a one-cycle done pulse. It sits between the dice-game score/roll logic and the seven-segment display driver.

---
 rtl/bcd_convert_ctrl.sv | 107 ++++++++++
 tb/tb_bcd_convert_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_ctrl.sv
// bcd_convert_ctrl: sequential binary-to-BCD converter.
// A single double-dabble (shift-add-3) stage is reused for BIN_WIDTH clock
// cycles. The packed-BCD result is registered and announced with a one-cycle
// done pulse. If the value does not fit in DIGITS decimal digits, the result
// saturates to all nines and overflow is set.
module bcd_convert_ctrl #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q;
  logic [BIN_WIDTH-1:0]  bin_sr_q;
  logic [BIN_WIDTH-1:0]  bin_sr_d;
  logic [4*DIGITS-1:0]   acc_q;
  logic [4*DIGITS-1:0]   acc_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  ovf_acc_q;
  logic                  ovf_acc_d;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_out_q;
  logic                  overflow_q;

  // Per-digit "add 3 if >= 5" adjustment, applied before the shift.
  logic [3:0] adj [DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign adj[gi] = (acc_q[4*gi +: 4] >= 4'd5) ? (acc_q[4*gi +: 4] + 4'd3)
                                                  : acc_q[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        // Lowest digit takes the next binary bit, MSB first.
        assign acc_d[3:0] = {adj[0][2:0], bin_sr_q[BIN_WIDTH-1]};
      end else begin : g_upper
        // Higher digits take the bit carried out of the digit below.
        assign acc_d[4*gi +: 4] = {adj[gi][2:0], adj[gi-1][3]};
      end
    end
  endgenerate

  // The bit pushed out of the top digit means the value no longer fits; the
  // flag is sticky so any lost bit forces saturation at the end.
  assign ovf_acc_d = ovf_acc_q | adj[DIGITS-1][3];
  assign bin_sr_d  = bin_sr_q << 1;
  assign cnt_d     = cnt_q - CNT_W'(1);

  // Control FSM and datapath registers; one shift/adjust step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_sr_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      done_q     <= 1'b0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_sr_q  <= bin_in;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= CNT_W'(BIN_WIDTH);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q     <= acc_d;
          ovf_acc_q <= ovf_acc_d;
          bin_sr_q  <= bin_sr_d;
          cnt_q     <= cnt_d;
          if (cnt_q == CNT_W'(1)) begin
            // Last step: publish the result (saturated on overflow).
            state_q    <= IDLE;
            done_q     <= 1'b1;
            overflow_q <= ovf_acc_d;
            bcd_out_q  <= ovf_acc_d ? {DIGITS{4'h9}} : acc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Testbench for bcd_convert_ctrl: directed and randomized conversions checked
// against a decimal-arithmetic reference model.
module tb_bcd_convert_ctrl;

  localparam int BW = 14;
  localparam int DG = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [BW-1:0]     bin_in;
  logic              busy;
  logic              done;
  logic [4*DG-1:0]   bcd_out;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  bcd_convert_ctrl #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits by division, saturating at 10^DG - 1.
  function automatic longint max_dec();
    longint lim = 1;
    for (int i = 0; i < DG; i++) lim = lim * 10;
    return lim - 1;
  endfunction

  function automatic logic [4*DG-1:0] model_bcd(input longint v);
    logic [4*DG-1:0] r;
    longint x;
    r = '0;
    x = (v > max_dec()) ? max_dec() : v;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input longint v);
    return v > max_dec();
  endfunction

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion and follow it to its done cycle (bounded).
  // lat = rising edges from the accepting edge up to the cycle where done is seen.
  task automatic do_conv(input int v, output int lat, output int busy_n,
                         output logic [4*DG-1:0] res, output logic ovf);
    start  = 1'b1;
    bin_in = BW'(v);
    step();
    start  = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (lat < 40) begin
      if (busy) busy_n++;
      if (done) break;
      step();
      lat++;
    end
    res = bcd_out;
    ovf = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin_in = '0;
    step(); step();
    checks++;
    if ({busy, done, overflow, bcd_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b ovf=%b bcd=%h expected all zero",
               busy, done, overflow, bcd_out);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    int vals [6] = '{255, 9999, 10000, 16383, 1, 5000};
    int lat, bn;
    logic [4*DG-1:0] res;
    logic ovf;
    foreach (vals[k]) begin
      do_conv(vals[k], lat, bn, res, ovf);
      checks++;
      if (res !== model_bcd(vals[k]) || ovf !== model_ovf(vals[k])) begin
        errors++;
        $display("FAIL directed_%0d: bcd=%h ovf=%b expected bcd=%h ovf=%b",
                 vals[k], res, ovf, model_bcd(vals[k]), model_ovf(vals[k]));
      end
      checks++;
      if (lat !== BW + 1 || bn !== BW) begin
        errors++;
        $display("FAIL directed_timing_%0d: latency=%0d busy_cycles=%0d expected %0d %0d",
                 vals[k], lat, bn, BW + 1, BW);
      end
      $display("directed bin=%0d bcd=%h ovf=%b latency=%0d", vals[k], res, ovf, lat);
      step();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse_width_%0d: done=%b expected 0", vals[k], done);
      end
    end
  endtask

  task automatic test_hold_previous();
    int lat, bn, n;
    logic [4*DG-1:0] res;
    logic ovf;
    do_conv(42, lat, bn, res, ovf);
    step();
    start = 1'b1; bin_in = '0;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      checks++;
      if (bcd_out !== model_bcd(42)) begin
        errors++;
        $display("FAIL hold_previous: bcd=%h expected %h", bcd_out, model_bcd(42));
      end
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1 || bcd_out !== model_bcd(0) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: done=%b bcd=%h ovf=%b expected 1 %h 0",
               done, bcd_out, overflow, model_bcd(0));
    end
    $display("hold_previous bin=0 bcd=%h cycles_held=%0d", bcd_out, n);
    step();
  endtask

  task automatic test_ignore_start();
    int c, dones;
    start = 1'b1; bin_in = BW'(42);
    step();
    c = 1; dones = 0;
    while (c < 25) begin
      start  = (c == 3 || c == 7);
      bin_in = BW'(77);
      if (done) dones++;
      step();
      c++;
    end
    start = 1'b0;
    checks++;
    if (dones !== 1 || bcd_out !== model_bcd(42)) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d bcd=%h expected 1 %h",
               dones, bcd_out, model_bcd(42));
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: busy=%b expected 0", busy);
    end
    $display("ignore_start bcd=%h dones=%0d", bcd_out, dones);
  endtask

  task automatic test_reset_mid();
    int dones, lat, bn;
    logic [4*DG-1:0] res;
    logic ovf;
    start = 1'b1; bin_in = BW'(1234);
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, overflow, bcd_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b ovf=%b bcd=%h expected all zero",
               busy, done, overflow, bcd_out);
    end
    dones = 0;
    repeat (20) begin
      if (done || busy) dones++;
      step();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_abandon: active_cycles=%0d expected 0", dones);
    end
    do_conv(56, lat, bn, res, ovf);
    checks++;
    if (res !== model_bcd(56) || lat !== BW + 1) begin
      errors++;
      $display("FAIL after_reset_conv: bcd=%h latency=%0d expected %h %0d",
               res, lat, model_bcd(56), BW + 1);
    end
    $display("reset_mid then bin=56 bcd=%h latency=%0d", res, lat);
    step();
    rst = 1'b1; start = 1'b1; bin_in = BW'(500);
    step();
    rst = 1'b0; start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    logic [4*DG-1:0] res;
    logic ovf;
    do_conv(123, lat, bn, res, ovf);
    checks++;
    if (res !== model_bcd(123)) begin
      errors++;
      $display("FAIL b2b_first: bcd=%h expected %h", res, model_bcd(123));
    end
    do_conv(4567, lat, bn, res, ovf);
    checks++;
    if (res !== model_bcd(4567) || lat !== BW + 1) begin
      errors++;
      $display("FAIL b2b_second: bcd=%h spacing=%0d expected %h %0d",
               res, lat, model_bcd(4567), BW + 1);
    end
    $display("back_to_back bin=4567 bcd=%h spacing=%0d", res, lat);
    step();
  endtask

  task automatic test_random();
    int v, lat, bn, gap;
    logic [4*DG-1:0] res;
    logic ovf;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) v = int'($urandom_range(9990, 10010));
      else                           v = int'($urandom_range(0, (1 << BW) - 1));
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
      do_conv(v, lat, bn, res, ovf);
      checks++;
      if (res !== model_bcd(v) || ovf !== model_ovf(v) || lat !== BW + 1) begin
        errors++;
        $display("FAIL random_%0d: bcd=%h ovf=%b latency=%0d expected %h %b %0d",
                 v, res, ovf, lat, model_bcd(v), model_ovf(v), BW + 1);
      end
      $display("random bin=%0d bcd=%h ovf=%b gap=%0d", v, res, ovf, gap);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_previous();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
